// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM state
// encoding and the default geometry used by the core and its bench.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_AW     = 5;
  localparam int DEF_NUM_RD = 2;

endpackage

// File: rtl/regfile_if.sv
// Bus bundle for the register file: packed read ports, two write ports
// and the bulk-clear request/busy handshake.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int AW     = DEF_AW,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD*AW-1:0]    raddr;
  logic [NUM_RD*WIDTH-1:0] rdata;
  logic                    wren0;
  logic [AW-1:0]           waddr0;
  logic [WIDTH-1:0]        wdata0;
  logic                    wren1;
  logic [AW-1:0]           waddr1;
  logic [WIDTH-1:0]        wdata1;
  logic                    clr_req;
  logic                    busy;

  modport master (
    output raddr, wren0, waddr0, wdata0, wren1, waddr1, wdata1, clr_req,
    input  rdata, busy
  );

  modport slave (
    input  raddr, wren0, waddr0, wdata0, wren1, waddr1, wdata1, clr_req,
    output rdata, busy
  );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: array mux, write-through bypass (port 1
// wins over port 0), hardwired-zero register 0 and blanking while busy.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = DEF_AW,
  parameter int ZERO_R0 = 1
) (
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] regs [DEPTH],
  input  logic             busy,
  input  logic             wren0,
  input  logic [AW-1:0]    waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             wren1,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic [WIDTH-1:0] rdata
);

  // Later assignments override earlier ones, giving the priority order
  // stored value < port 0 bypass < port 1 bypass < zero/busy forcing.
  always_comb begin
    rdata = regs[raddr];
    if (wren0 && (waddr0 == raddr)) begin
      rdata = wdata0;
    end
    if (wren1 && (waddr1 == raddr)) begin
      rdata = wdata1;
    end
    if (busy || ((ZERO_R0 != 0) && (raddr == '0))) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: flop storage with async reset,
// two write ports (port 1 wins on address collision), NUM_RD bypassing
// read ports and a sequenced bulk clear that zeroes one entry per cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = DEF_AW,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int ZERO_R0 = 1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t                  state;
  state_t                  state_next;
  logic [AW-1:0]           cnt;
  logic [WIDTH-1:0]        regs [DEPTH];
  logic                    busy;
  logic                    we0;
  logic                    we1;
  logic [NUM_RD*WIDTH-1:0] rdata_flat;

  assign busy = (state == ST_CLEAR);

  // Writes are dropped while clearing and, when register 0 is hardwired,
  // whenever they target address 0.
  assign we0 = bus.wren0 && !busy && !((ZERO_R0 != 0) && (bus.waddr0 == '0));
  assign we1 = bus.wren1 && !busy && !((ZERO_R0 != 0) && (bus.waddr1 == '0));

  // Clear FSM state and sweep counter; the counter restarts from 0 on
  // every entry into CLEAR because it is held at 0 while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // Next-state logic: a request in IDLE starts a sweep, the last entry ends it.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.clr_req)      state_next = ST_CLEAR;
      ST_CLEAR: if (cnt == LAST_IDX)  state_next = ST_IDLE;
      default:                        state_next = ST_IDLE;
    endcase
  end

  // Storage: sweep zeroing during CLEAR, otherwise port 0 then port 1 so
  // that port 1 data survives an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (busy) begin
      regs[cnt] <= '0;
    end else begin
      if (we0) begin
        regs[bus.waddr0] <= bus.wdata0;
      end
      if (we1) begin
        regs[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rdport #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .ZERO_R0(ZERO_R0)
    ) u_rdport (
      .raddr (bus.raddr[k*AW +: AW]),
      .regs  (regs),
      .busy  (busy),
      .wren0 (bus.wren0),
      .waddr0(bus.waddr0),
      .wdata0(bus.wdata0),
      .wren1 (bus.wren1),
      .waddr1(bus.waddr1),
      .wdata1(bus.wdata1),
      .rdata (rdata_flat[k*WIDTH +: WIDTH])
    );
  end

  assign bus.rdata = rdata_flat;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, reset/clear sequences and
// randomized traffic against a behavioural model of the register file.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int D  = DEF_DEPTH;
  localparam int AW = DEF_AW;
  localparam int NR = DEF_NUM_RD;

  logic clk;
  logic rst;

  regfile_if #(.WIDTH(W), .AW(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(
    .WIDTH  (W),
    .DEPTH  (D),
    .AW     (AW),
    .NUM_RD (NR),
    .ZERO_R0(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we0;
    logic [AW-1:0] a0;
    logic [W-1:0]  d0;
    logic          we1;
    logic [AW-1:0] a1;
    logic [W-1:0]  d1;
    logic [AW-1:0] r0;
    logic [AW-1:0] r1;
    logic [W-1:0]  e0;
    logic [W-1:0]  e1;
    logic          eb;
    string         name;
  } vec_t;

  vec_t         vecs [8];
  logic [W-1:0] model_regs [D];
  int           clear_left;
  int           n_checks;
  int           n_fails;

  // Model: a plain array plus a count of remaining clear cycles.
  task automatic model_reset();
    for (int i = 0; i < D; i++) model_regs[i] = '0;
    clear_left = 0;
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] addr);
    logic [W-1:0] v;
    if (clear_left > 0 || addr == 0) return '0;
    v = model_regs[addr];
    if (bus.wren0 && bus.waddr0 == addr) v = bus.wdata0;
    if (bus.wren1 && bus.waddr1 == addr) v = bus.wdata1;
    return v;
  endfunction

  // Applied once per rising edge with the inputs that were present at it.
  task automatic model_commit();
    if (clear_left > 0) begin
      clear_left--;
    end else if (bus.clr_req) begin
      clear_left = D;
      for (int i = 0; i < D; i++) model_regs[i] = '0;
    end else begin
      if (bus.wren0 && bus.waddr0 != 0) model_regs[bus.waddr0] = bus.wdata0;
      if (bus.wren1 && bus.waddr1 != 0) model_regs[bus.waddr1] = bus.wdata1;
    end
  endtask

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                       input logic w1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                       input logic clr, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    bus.wren0   = w0;
    bus.waddr0  = a0;
    bus.wdata0  = d0;
    bus.wren1   = w1;
    bus.waddr1  = a1;
    bus.wdata1  = d1;
    bus.clr_req = clr;
    bus.raddr   = {r1, r0};
  endtask

  task automatic apply_stimulus(input vec_t v);
    drive(v.we0, v.a0, v.d0, v.we1, v.a1, v.d1, 1'b0, v.r0, v.r1);
    #2;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // One full cycle checked against the model; reports the sampled busy.
  task automatic do_cycle(input logic w0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                          input logic w1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                          input logic clr, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                          input string tag, output logic busy_seen);
    drive(w0, a0, d0, w1, a1, d1, clr, r0, r1);
    #2;
    busy_seen = bus.busy;
    check_output({tag, "_rd0"}, bus.rdata[0*W +: W], exp_rd(r0));
    check_output({tag, "_rd1"}, bus.rdata[1*W +: W], exp_rd(r1));
    check_output({tag, "_busy"}, {{(W-1){1'b0}}, bus.busy}, {{(W-1){1'b0}}, (clear_left > 0)});
    finish_cycle();
  endtask

  initial begin
    logic b;
    int   busy_cnt;
    n_checks = 0;
    n_fails  = 0;
    model_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, "bypass_p0"};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "stored_r5"};
    vecs[2] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 5'd7, 5'd5, 32'h22,        32'hDEADBEEF, 1'b0, "collide_bypass"};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 5'd7, 32'h22,        32'h22,       1'b0, "collide_stored"};
    vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0,   32'h22,       1'b0, "r0_write"};
    vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 32'h0,         32'h0,        1'b0, "r0_after"};
    vecs[6] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'h99, 5'd3, 5'd9, 32'h33,        32'h99,       1'b0, "dual_write"};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd9, 5'd3, 32'h99,        32'h33,       1'b0, "dual_stored"};

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      check_output({vecs[i].name, "_rd0"}, bus.rdata[0*W +: W], vecs[i].e0);
      check_output({vecs[i].name, "_rd1"}, bus.rdata[1*W +: W], vecs[i].e1);
      check_output({vecs[i].name, "_busy"}, {{(W-1){1'b0}}, bus.busy}, {{(W-1){1'b0}}, vecs[i].eb});
      finish_cycle();
    end

    $display("[TB] async reset mid-cycle");
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd5, 5'd9);
    #2;
    rst = 1'b1;
    #1;
    check_output("rst_rd0", bus.rdata[0*W +: W], '0);
    check_output("rst_rd1", bus.rdata[1*W +: W], '0);
    check_output("rst_busy", {{(W-1){1'b0}}, bus.busy}, '0);
    model_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i < D; i++) begin
      do_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, AW'(i), AW'(D - i), "rst_read", b);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a0, a1, r0, r1;
      a0 = AW'($urandom_range(0, D - 1));
      a1 = ($urandom_range(0, 1) == 1) ? a0 : AW'($urandom_range(0, D - 1));
      r0 = ($urandom_range(0, 1) == 1) ? a0 : AW'($urandom_range(0, D - 1));
      r1 = ($urandom_range(0, 1) == 1) ? a1 : AW'($urandom_range(0, D - 1));
      do_cycle(1'($urandom_range(0, 1)), a0, $urandom, 1'($urandom_range(0, 1)), a1, $urandom,
               ($urandom_range(0, 59) == 0), r0, r1, "rand", b);
    end
    while (clear_left > 0) begin
      do_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd1, 5'd2, "drain", b);
    end

    $display("[TB] bulk clear");
    for (int i = 1; i < D; i++) begin
      do_cycle(1'b1, AW'(i), W'(i), 1'b0, '0, '0, 1'b0, AW'(i), AW'(i - 1), "fill", b);
    end
    do_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd31, "clr_pulse", b);
    busy_cnt = 0;
    for (int c = 0; c < D + 8; c++) begin
      do_cycle(c == 5, 5'd3, 32'h55, 1'b0, '0, '0, 1'b0, 5'd3, 5'd30, "clearing", b);
      if (b) busy_cnt++;
    end
    check_output("clear_busy_cycles", W'(busy_cnt), W'(D));
    for (int i = 0; i < D; i += 2) begin
      do_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, AW'(i), AW'(i + 1), "post_clear", b);
    end
    check_output("post_clear_r3", exp_rd(5'd3), '0);

    $display("[TB] reset during clear");
    for (int i = 1; i <= 12; i++) begin
      do_cycle(1'b0, '0, '0, 1'b1, AW'(i), W'(i + 100), 1'b0, AW'(i), 5'd0, "fill2", b);
    end
    do_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12, 5'd1, "clr2", b);
    for (int c = 0; c < 10; c++) begin
      do_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd12, 5'd11, "clear2", b);
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd12, 5'd11);
    #2;
    rst = 1'b1;
    #1;
    check_output("abort_busy", {{(W-1){1'b0}}, bus.busy}, '0);
    model_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_cycle(1'b1, 5'd4, 32'h1234, 1'b0, '0, '0, 1'b0, 5'd4, 5'd12, "post_abort_wr", b);
    do_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd4, 5'd12, "post_abort_rd", b);
    check_output("post_abort_r4", exp_rd(5'd4), 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
